// File: rtl/emif_calbus_pkg.sv
// rtl/emif_calbus_pkg.sv - shared constants and types for the calbus responder
//
// Purpose: CSR address offsets, parameter-table address window, CTRL bit
// positions and the init/ready state type used by emif_calbus_responder.
// Ports: none (package).
package emif_calbus_pkg;

  // Word-aligned byte offsets of the CSR block.
  localparam logic [19:0] OFS_CTRL      = 20'h01000;
  localparam logic [19:0] OFS_STATUS    = 20'h01004;
  localparam logic [19:0] OFS_SCRATCH   = 20'h01008;
  localparam logic [19:0] OFS_WR_COUNT  = 20'h0100C;
  localparam logic [19:0] OFS_ERR_COUNT = 20'h01010;
  localparam logic [19:0] OFS_ERR_ADDR  = 20'h01014;

  // Parameter table occupies 128 words starting at byte 0.
  localparam logic [19:0] TBL_BASE  = 20'h00000;
  localparam logic [19:0] TBL_LIMIT = 20'h001FC;
  localparam int          TBL_WORDS = 128;
  localparam int          TBL_IDX_W = 7;

  // CTRL register bit positions.
  localparam int CTRL_CAL_DONE = 0;
  localparam int CTRL_CAL_FAIL = 1;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } cal_state_e;

endpackage

// File: rtl/emif_calbus_param_tbl.sv
// rtl/emif_calbus_param_tbl.sv - 128x32 flop-array sequencer parameter table
//
// Purpose: per-bank parameter storage with one write port, one registered
// read port and the whole array exposed as a flat vector.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (clears array)
//   we_i/waddr_i/wdata_i  single write port
//   re_i/raddr_i       read request; rdata_o updates on the next edge and holds
//   rdata_o            registered read data
//   tbl_o              flat table, word i at [32i+31:32i]
module emif_calbus_param_tbl
  import emif_calbus_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            we_i,
  input  logic [TBL_IDX_W-1:0]            waddr_i,
  input  logic [DATA_WIDTH-1:0]           wdata_i,
  input  logic                            re_i,
  input  logic [TBL_IDX_W-1:0]            raddr_i,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic [TBL_WORDS*DATA_WIDTH-1:0] tbl_o
);

  logic [DATA_WIDTH-1:0] mem_q [TBL_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read samples the array before this edge's write lands, so a same-cycle
  // read of the written word returns the old contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < TBL_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  always_comb begin
    tbl_o = '0;
    for (int i = 0; i < TBL_WORDS; i++) begin
      tbl_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/emif_calbus_responder.sv
// rtl/emif_calbus_responder.sv - calbus target endpoint for one IO bank
//
// Purpose: decodes calbus read/write strobes, owns the parameter table and
// CSR set, walks the table with a seed pattern after reset, and returns
// registered read data one cycle after each read strobe.
// Ports:
//   calbus_clk, calbus_reset    clock, synchronous active-high reset
//   calbus_read, calbus_write   single-cycle strobes
//   calbus_address              byte address, bits [1:0] ignored for decode
//   calbus_wdata, calbus_rdata  write data in, registered read data out
//   calbus_seq_param_tbl        flat parameter table
//   hw_status                   live hardware status shown in STATUS
//   init_done                   table seeding complete
//   cal_done, cal_fail          CTRL bits 0 and 1
module emif_calbus_responder
  import emif_calbus_pkg::*;
#(
  parameter logic [7:0] BANK_ID     = 8'h00,
  parameter int         PARAM_WORDS = 128,
  parameter int         ADDR_WIDTH  = 20,
  parameter int         DATA_WIDTH  = 32
) (
  input  logic                              calbus_clk,
  input  logic                              calbus_reset,
  input  logic                              calbus_read,
  input  logic                              calbus_write,
  input  logic [ADDR_WIDTH-1:0]             calbus_address,
  input  logic [DATA_WIDTH-1:0]             calbus_wdata,
  output logic [DATA_WIDTH-1:0]             calbus_rdata,
  output logic [PARAM_WORDS*DATA_WIDTH-1:0] calbus_seq_param_tbl,
  input  logic [7:0]                        hw_status,
  output logic                              init_done,
  output logic                              cal_done,
  output logic                              cal_fail
);

  cal_state_e             state_q, state_d;
  logic [TBL_IDX_W-1:0]   idx_q, idx_d;
  logic                   init_done_q;
  logic [1:0]             ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0]  scratch_q, scratch_d;
  logic [15:0]            wr_cnt_q, wr_cnt_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0]  err_addr_q, err_addr_d;
  logic [DATA_WIDTH-1:0]  csr_rdata_q, csr_rdata_d;
  logic                   rd_tbl_q, rd_tbl_d;

  logic [ADDR_WIDTH-1:0]  addr_w;
  logic hit_tbl, hit_ctrl, hit_status, hit_scratch, hit_wr_cnt, hit_err_cnt, hit_err_addr;
  logic rd_mapped, wr_mapped, ready, rd_acc, wr_acc, err_ev;
  logic [DATA_WIDTH-1:0]  csr_rd_val;

  logic                   tbl_we, tbl_re;
  logic [TBL_IDX_W-1:0]   tbl_waddr;
  logic [DATA_WIDTH-1:0]  tbl_wdata, tbl_rdata;

  // Address decode and strobe qualification.
  always_comb begin
    addr_w       = {calbus_address[ADDR_WIDTH-1:2], 2'b00};
    // Table base is 0, so only the upper limit needs checking.
    hit_tbl      = (addr_w <= TBL_LIMIT);
    hit_ctrl     = (addr_w == OFS_CTRL);
    hit_status   = (addr_w == OFS_STATUS);
    hit_scratch  = (addr_w == OFS_SCRATCH);
    hit_wr_cnt   = (addr_w == OFS_WR_COUNT);
    hit_err_cnt  = (addr_w == OFS_ERR_COUNT);
    hit_err_addr = (addr_w == OFS_ERR_ADDR);
    rd_mapped    = hit_tbl | hit_ctrl | hit_status | hit_scratch |
                   hit_wr_cnt | hit_err_cnt | hit_err_addr;
    wr_mapped    = hit_tbl | hit_ctrl | hit_scratch;
    ready        = (state_q == ST_READY);
    rd_acc       = ready & calbus_read;
    wr_acc       = ready & calbus_write & wr_mapped;
    // A read+write collision counts as exactly one error; both strobes share
    // the address bus, so ERR_ADDR is the write address in that case.
    err_ev       = ready & ((calbus_read & calbus_write) |
                            (calbus_read & ~rd_mapped) |
                            (calbus_write & ~wr_mapped));
  end

  // Init walker FSM; also steers the shared table write port.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tbl_we    = 1'b0;
    tbl_waddr = addr_w[TBL_IDX_W+1:2];
    tbl_wdata = calbus_wdata;
    unique case (state_q)
      ST_INIT: begin
        tbl_we    = 1'b1;
        tbl_waddr = idx_q;
        tbl_wdata = {BANK_ID, 8'h00, 9'd0, idx_q};
        idx_d     = idx_q + 1'b1;
        if (idx_q == TBL_IDX_W'(TBL_WORDS - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        tbl_we = wr_acc & hit_tbl;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // CSR updates and read-data capture. Reads see pre-write register values.
  always_comb begin
    ctrl_d      = ctrl_q;
    scratch_d   = scratch_q;
    wr_cnt_d    = wr_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_addr_d  = err_addr_q;
    csr_rdata_d = csr_rdata_q;
    rd_tbl_d    = rd_tbl_q;
    tbl_re      = rd_acc & hit_tbl;

    csr_rd_val = '0;
    if (hit_ctrl)     csr_rd_val = DATA_WIDTH'(ctrl_q);
    if (hit_status)   csr_rd_val = DATA_WIDTH'({BANK_ID, hw_status});
    if (hit_scratch)  csr_rd_val = scratch_q;
    if (hit_wr_cnt)   csr_rd_val = DATA_WIDTH'(wr_cnt_q);
    if (hit_err_cnt)  csr_rd_val = DATA_WIDTH'(err_cnt_q);
    if (hit_err_addr) csr_rd_val = DATA_WIDTH'(err_addr_q);

    if (wr_acc) begin
      if (hit_ctrl)    ctrl_d    = calbus_wdata[1:0];
      if (hit_scratch) scratch_d = calbus_wdata;
      if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (err_ev) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      err_addr_d = calbus_address;
    end
    if (rd_acc) begin
      rd_tbl_d    = hit_tbl;
      csr_rdata_d = csr_rd_val;
    end
  end

  always_ff @(posedge calbus_clk) begin
    if (calbus_reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      ctrl_q      <= '0;
      scratch_q   <= '0;
      wr_cnt_q    <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      csr_rdata_q <= '0;
      rd_tbl_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      init_done_q <= (state_q == ST_READY);
      ctrl_q      <= ctrl_d;
      scratch_q   <= scratch_d;
      wr_cnt_q    <= wr_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      csr_rdata_q <= csr_rdata_d;
      rd_tbl_q    <= rd_tbl_d;
    end
  end

  emif_calbus_param_tbl #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_param_tbl (
    .clk_i   (calbus_clk),
    .rst_i   (calbus_reset),
    .we_i    (tbl_we),
    .waddr_i (tbl_waddr),
    .wdata_i (tbl_wdata),
    .re_i    (tbl_re),
    .raddr_i (addr_w[TBL_IDX_W+1:2]),
    .rdata_o (tbl_rdata),
    .tbl_o   (calbus_seq_param_tbl)
  );

  // The read source flag picks whichever registered value the last read loaded.
  assign calbus_rdata = rd_tbl_q ? tbl_rdata : csr_rdata_q;
  assign init_done    = init_done_q;
  assign cal_done     = ctrl_q[CTRL_CAL_DONE];
  assign cal_fail     = ctrl_q[CTRL_CAL_FAIL];

endmodule
